// File: rtl/cmd_submit_pkg.sv
// Shared definitions for the MMIO command submission bridge: register map,
// command length and the 4-bit state encoding seen by the debug probe.
package cmd_submit_pkg;

  localparam logic [2:0] ADDR_CMD_WORD0  = 3'd0;
  localparam logic [2:0] ADDR_CMD_WORD1  = 3'd1;
  localparam logic [2:0] ADDR_CMD_WORD2  = 3'd2;
  localparam logic [2:0] ADDR_CMD_WORD3  = 3'd3;
  localparam logic [2:0] ADDR_CMD_SUBMIT = 3'd4;

  localparam int CMD_WORDS = 4;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CHECK = 4'd1,
    PUSH  = 4'd2,
    DONE  = 4'd3
  } cmd_sub_state_t;

endpackage

// File: rtl/cmd_submit_bridge.sv
// Command submission bridge: snapshots CMD_WORD0..3 on a CMD_SUBMIT write and
// pushes them into the command FIFO once space exists. Optional space-wait
// timeout is enabled with `define CMD_SUBMIT_TIMEOUT_EN.
module cmd_submit_bridge
  import cmd_submit_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4096,
  parameter int CNT_W          = 13,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_reg_wr,
  input  logic [2:0]       i_reg_addr,
  input  logic [31:0]      i_reg_wdata,
  input  logic [CNT_W-1:0] i_cmd_fifo_count,
  output logic [31:0]      o_cmd_word0,
  output logic [31:0]      o_cmd_word1,
  output logic [31:0]      o_cmd_word2,
  output logic [31:0]      o_cmd_word3,
  output logic [31:0]      o_cmd_submit_reg,
  output logic             o_write_strobe,
  output logic             o_cmd_fifo_wen,
  output logic [31:0]      o_cmd_fifo_wdata,
  output logic             o_engine_submit,
  output logic             o_busy,
  output logic [15:0]      o_submit_count,
  output logic [7:0]       o_drop_count,
  output logic             o_err_overflow,
  output logic             o_err_timeout
);

  // Empty tripwire block: only elaborates under an illegal configuration.
  if ((2 ** CNT_W) <= FIFO_DEPTH || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_config
  end

  logic [CMD_WORDS-1:0][31:0] word_q, word_d;
  logic [CMD_WORDS-1:0][31:0] stage_q, stage_d;
  logic [31:0]                submit_reg_q, submit_reg_d;
  cmd_sub_state_t             state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic                       write_strobe_q, write_strobe_d;
  logic [15:0]                submit_count_q, submit_count_d;
  logic [7:0]                 drop_count_q, drop_count_d;
  logic                       err_overflow_q, err_overflow_d;
  logic [CNT_W:0]             need_words;
  logic                       space_ok;
  logic                       submit_hit;

  // Extra bit keeps count + CMD_WORDS from wrapping near a full FIFO.
  assign need_words = {1'b0, i_cmd_fifo_count} + (CNT_W+1)'(CMD_WORDS);
  assign space_ok   = need_words <= (CNT_W+1)'(FIFO_DEPTH);
  assign submit_hit = i_reg_wr && (i_reg_addr == ADDR_CMD_SUBMIT);

`ifdef CMD_SUBMIT_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic        err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and infers a latch.
    word_d         = word_q;
    stage_d        = stage_q;
    submit_reg_d   = submit_reg_q;
    state_d        = state_q;
    idx_d          = idx_q;
    submit_count_d = submit_count_q;
    drop_count_d   = drop_count_q;
    err_overflow_d = err_overflow_q;
    write_strobe_d = i_reg_wr && (i_reg_addr <= ADDR_CMD_SUBMIT);
`ifdef CMD_SUBMIT_TIMEOUT_EN
    err_timeout_d  = err_timeout_q;
`endif

    if (i_reg_wr && (i_reg_addr < ADDR_CMD_SUBMIT)) begin
      word_d[i_reg_addr[1:0]] = i_reg_wdata;
    end

    if (submit_hit) begin
      submit_reg_d = i_reg_wdata;
      if (state_q == IDLE) begin
        stage_d = word_q;
        state_d = CHECK;
      end else begin
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        err_overflow_d = 1'b1;
      end
    end

    case (state_q)
      CHECK: begin
        if (space_ok) begin
          state_d = PUSH;
          idx_d   = 2'd0;
        end
`ifdef CMD_SUBMIT_TIMEOUT_EN
        else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end
`endif
      end
      PUSH: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(CMD_WORDS - 1)) state_d = DONE;
      end
      DONE: begin
        state_d        = IDLE;
        submit_count_d = submit_count_q + 16'd1;
      end
      default: ;
    endcase
  end

`ifdef CMD_SUBMIT_TIMEOUT_EN
  assign timer_d = (state_q == CHECK && state_d == CHECK) ? timer_q + 16'd1 : 16'd0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer_q       <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign o_err_timeout = err_timeout_q;
`else
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the staging buffer is reset too, so an abandoned command never leaks stale words onto the FIFO bus.
      word_q         <= '0;
      stage_q        <= '0;
      submit_reg_q   <= '0;
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      write_strobe_q <= 1'b0;
      submit_count_q <= 16'd0;
      drop_count_q   <= 8'd0;
      err_overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of its peers.
      word_q         <= word_d;
      stage_q        <= stage_d;
      submit_reg_q   <= submit_reg_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      write_strobe_q <= write_strobe_d;
      submit_count_q <= submit_count_d;
      drop_count_q   <= drop_count_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign o_cmd_word0      = word_q[0];
  assign o_cmd_word1      = word_q[1];
  assign o_cmd_word2      = word_q[2];
  assign o_cmd_word3      = word_q[3];
  assign o_cmd_submit_reg = submit_reg_q;
  assign o_write_strobe   = write_strobe_q;
  assign o_cmd_fifo_wen   = (state_q == PUSH);
  assign o_cmd_fifo_wdata = (state_q == PUSH) ? stage_q[idx_q] : 32'd0;
  assign o_engine_submit  = (state_q == DONE);
  assign o_busy           = (state_q != IDLE);
  assign o_submit_count   = submit_count_q;
  assign o_drop_count     = drop_count_q;
  assign o_err_overflow   = err_overflow_q;

endmodule

// File: tb/tb_cmd_submit_bridge.sv
// Scoreboard bench for cmd_submit_bridge: a timestamp-level model schedules the
// expected FIFO writes and engine pulses; a negedge monitor compares them.
module tb_cmd_submit_bridge;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_reg_wr = 1'b0;
  logic [2:0]  i_reg_addr = 3'd0;
  logic [31:0] i_reg_wdata = 32'd0;
  logic [12:0] i_cmd_fifo_count = 13'd0;
  logic [31:0] o_cmd_word0, o_cmd_word1, o_cmd_word2, o_cmd_word3;
  logic [31:0] o_cmd_submit_reg;
  logic        o_write_strobe, o_cmd_fifo_wen, o_engine_submit, o_busy;
  logic [31:0] o_cmd_fifo_wdata;
  logic [15:0] o_submit_count;
  logic [7:0]  o_drop_count;
  logic        o_err_overflow, o_err_timeout;

  cmd_submit_bridge dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_reg_wr(i_reg_wr), .i_reg_addr(i_reg_addr),
    .i_reg_wdata(i_reg_wdata), .i_cmd_fifo_count(i_cmd_fifo_count),
    .o_cmd_word0(o_cmd_word0), .o_cmd_word1(o_cmd_word1), .o_cmd_word2(o_cmd_word2),
    .o_cmd_word3(o_cmd_word3), .o_cmd_submit_reg(o_cmd_submit_reg),
    .o_write_strobe(o_write_strobe), .o_cmd_fifo_wen(o_cmd_fifo_wen),
    .o_cmd_fifo_wdata(o_cmd_fifo_wdata), .o_engine_submit(o_engine_submit),
    .o_busy(o_busy), .o_submit_count(o_submit_count), .o_drop_count(o_drop_count),
    .o_err_overflow(o_err_overflow), .o_err_timeout(o_err_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } wen_exp_t;

  wen_exp_t wq[$];
  int       eq[$];
  int       total = 0;
  int       bad = 0;

  // Reference model state: register contents plus timestamps of the pending command.
  logic [31:0] m_words[4];
  logic [31:0] m_stage[4];
  logic [31:0] m_submit_reg;
  logic [15:0] m_submit_cnt;
  int          m_drop;
  logic        m_ovf, m_strobe, m_pending;
  int          m_check_from, m_free_at, m_bump_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_words[i] = 32'd0;
      m_stage[i] = 32'd0;
    end
    m_submit_reg = 32'd0;
    m_submit_cnt = 16'd0;
    m_drop       = 0;
    m_ovf        = 1'b0;
    m_strobe     = 1'b0;
    m_pending    = 1'b0;
    m_check_from = 0;
    m_free_at    = 0;
    m_bump_at    = -1;
    wq.delete();
    eq.delete();
  endtask

  // One bus cycle: compare registered outputs, drive inputs, advance the model.
  task automatic step(input logic wr, input logic [2:0] addr, input logic [31:0] data,
                      input logic [12:0] count);
    int c;
    c = cyc;
    if (c == m_bump_at) m_submit_cnt++;
    check("word0", o_cmd_word0, m_words[0]);
    check("word1", o_cmd_word1, m_words[1]);
    check("word2", o_cmd_word2, m_words[2]);
    check("word3", o_cmd_word3, m_words[3]);
    check("submit_reg", o_cmd_submit_reg, m_submit_reg);
    check("write_strobe", o_write_strobe, m_strobe);
    check("busy", o_busy, (m_pending || c < m_free_at));
    check("submit_count", o_submit_count, m_submit_cnt);
    check("drop_count", o_drop_count, m_drop);
    check("err_overflow", o_err_overflow, m_ovf);
`ifndef CMD_SUBMIT_TIMEOUT_EN
    check("err_timeout", o_err_timeout, 1'b0);
`endif

    i_reg_wr         = wr;
    i_reg_addr       = addr;
    i_reg_wdata      = data;
    i_cmd_fifo_count = count;

    // A waiting command launches in the first cycle after its submit that sees room for 4 words.
    if (m_pending && c >= m_check_from && (int'(count) + 4 <= 4096)) begin
      for (int i = 0; i < 4; i++) wq.push_back('{cyc: c + 1 + i, data: m_stage[i]});
      eq.push_back(c + 5);
      m_free_at = c + 6;
      m_bump_at = c + 6;
      m_pending = 1'b0;
    end

    m_strobe = wr && (addr <= 3'd4);
    if (wr && addr < 3'd4) m_words[addr[1:0]] = data;
    if (wr && addr == 3'd4) begin
      m_submit_reg = data;
      if (!m_pending && c >= m_free_at) begin
        m_stage      = m_words;
        m_pending    = 1'b1;
        m_check_from = c + 1;
      end else begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1'b1;
      end
    end

    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [12:0] count);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, count);
  endtask

  task automatic pulse_reset();
    i_reset_n = 1'b0;
    i_reg_wr  = 1'b0;
    #1;
    check("rst_wen", o_cmd_fifo_wen, 1'b0);
    check("rst_wdata", o_cmd_fifo_wdata, 32'd0);
    check("rst_engine", o_engine_submit, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_word0", o_cmd_word0, 32'd0);
    check("rst_submit_count", o_submit_count, 16'd0);
    check("rst_drop_count", o_drop_count, 8'd0);
    check("rst_err_overflow", o_err_overflow, 1'b0);
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  // Monitor: each cycle the head of each queue says whether a pulse is due now.
  always @(negedge i_clk) begin
    logic exp_wen, exp_eng;
    exp_wen = (wq.size() > 0) && (wq[0].cyc == cyc);
    exp_eng = (eq.size() > 0) && (eq[0] == cyc);
    check("fifo_wen", o_cmd_fifo_wen, exp_wen);
    if (exp_wen) begin
      check("fifo_wdata", o_cmd_fifo_wdata, wq[0].data);
      void'(wq.pop_front());
    end
    check("engine_submit", o_engine_submit, exp_eng);
    if (exp_eng) void'(eq.pop_front());
  end

  initial begin
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("init_wen", o_cmd_fifo_wen, 1'b0);
    check("init_busy", o_busy, 1'b0);
    check("init_submit_reg", o_cmd_submit_reg, 32'd0);
    i_reset_n = 1'b1;

    // Basic command with an empty FIFO.
    step(1'b1, 3'd0, 32'h11, 13'd0);
    step(1'b1, 3'd1, 32'h22, 13'd0);
    step(1'b1, 3'd2, 32'h33, 13'd0);
    step(1'b1, 3'd3, 32'h44, 13'd0);
    step(1'b1, 3'd4, 32'h0, 13'd0);
    idle(8, 13'd0);

    // Nearly full FIFO: 4093 holds in the space check, 4092 releases it.
    step(1'b1, 3'd4, 32'hDEAD, 13'd4093);
    idle(6, 13'd4093);
    idle(8, 13'd4092);

    // Submit while pushing is dropped; word0 rewrite mid-push reaches only the next command.
    step(1'b1, 3'd1, 32'h5555_0001, 13'd0);
    step(1'b1, 3'd4, 32'h1, 13'd0);
    step(1'b1, 3'd0, 32'hBEEF, 13'd0);
    step(1'b0, 3'd0, 32'd0, 13'd0);
    step(1'b1, 3'd0, 32'hAA, 13'd0);
    step(1'b1, 3'd4, 32'h2, 13'd0);
    idle(6, 13'd0);
    step(1'b1, 3'd4, 32'h3, 13'd0);
    idle(8, 13'd0);

    // Reset after the second FIFO write abandons the command.
    step(1'b1, 3'd4, 32'h4, 13'd0);
    idle(3, 13'd0);
    pulse_reset();
    idle(8, 13'd0);
    step(1'b1, 3'd2, 32'hC0DE, 13'd0);
    step(1'b1, 3'd4, 32'h5, 13'd0);
    idle(8, 13'd0);

    // Randomized traffic, including ignored addresses 5-7 and a saturating drop counter.
    for (int i = 0; i < 1500; i++) begin
      logic        wr;
      logic [2:0]  addr;
      logic [12:0] count;
      wr   = ($urandom_range(0, 2) != 0);
      addr = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       count = 13'($urandom_range(0, 4092));
        1:       count = 13'($urandom_range(4093, 4096));
        2:       count = 13'd4092;
        default: count = 13'd0;
      endcase
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step(wr, addr, $urandom, count);
    end

    idle(20, 13'd0);
    check("drain_wen_queue", wq.size(), 0);
    check("drain_engine_queue", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
